ysyx_25040109_core_ctrl: RTL and testbench
==========================================

YSYX_25040109_CORE_CTRL -- requirements
Module: ysyx_25040109_core_ctrl

Interface
REQ-001 SHALL have clock and reset: clk input 1 (single clock, rising edge); rst_n input 1 (asynchronous, active-low).
REQ-002 SHALL have ifu_req output 1: fetch request, held until accepted.
REQ-003 SHALL have ifu_rvalid input 1: instruction word valid from fetch.
REQ-004 SHALL have inst_we output 1: one-cycle pulse latching the fetched word into the instruction register.
REQ-005 SHALL have the following decode-status inputs, each 1 bit and valid in DECODE/EXEC/MEM/WB: inst_invalid, reg_write_en_idu, is_load, is_store, is_muldiv, is_ebreak.
REQ-006 SHALL have the multiply/divide unit ports: muldiv_start output 1, a start pulse; muldiv_done input 1, result ready.
REQ-007 SHALL have the load/store unit ports: lsu_req output 1, held; lsu_done input 1, access complete.
REQ-008 SHALL have rf_wen output 1 and pc_we output 1: write-back strobes for the register file and the PC.
REQ-009 SHALL have halt output 1 (sticky stop) and trap_illegal output 1 (sticky illegal-instruction flag).
REQ-010 SHALL have state_o output 3: current FSM state, for debug.
REQ-011 SHALL have cycle_cnt output 64 and inst_cnt output 64; these exist only under the macro in REQ-030.

Function
REQ-012 SHALL implement a Moore FSM with these encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
REQ-013 IDLE SHALL drive all strobes low and go to FETCH on the next cycle.
REQ-014 FETCH SHALL assert ifu_req; on ifu_rvalid it SHALL pulse inst_we in that same cycle and go to DECODE; otherwise it stays in FETCH.
REQ-015 DECODE SHALL select the next state by priority:
- inst_invalid -> TRAP;
- else is_ebreak -> HALT;
- else -> EXEC.
REQ-016 EXEC with is_muldiv=0 SHALL last exactly one cycle.
REQ-017 EXEC with is_muldiv=1 SHALL pulse muldiv_start on the first EXEC cycle only, then wait for muldiv_done; muldiv_done SHALL be accepted on any EXEC cycle, including the first.
REQ-018 On leaving EXEC: if (is_load|is_store) -> MEM, else -> WB; both flags high SHALL still produce a single MEM visit.
REQ-019 MEM SHALL hold lsu_req high until lsu_done is sampled, then go to WB.
REQ-020 WB SHALL last one cycle:
- rf_wen = reg_write_en_idu;
- pc_we = 1;
- then -> FETCH.
REQ-021 HALT SHALL be terminal with halt=1; TRAP SHALL be terminal with halt=1 and trap_illegal=1; only rst_n exits either state.
REQ-022 ifu_rvalid outside FETCH, muldiv_done outside EXEC, and lsu_done outside MEM SHALL be ignored.
REQ-023 Minimum latencies with zero-wait responders, measured from FETCH entry to FETCH re-entry:
- ALU instruction: 4 cycles;
- load/store: 5 cycles;
- muldiv: 4 + (muldiv_done wait) cycles.
REQ-024 All strobes SHALL be decoded from the state register plus the listed inputs only; no strobe SHALL be asserted in IDLE, HALT or TRAP, except halt and trap_illegal as stated in REQ-021.

Reset
REQ-025 While rst_n=0 the state SHALL be IDLE, and every output SHALL be 0 with state_o=0.
REQ-026 Assertion of rst_n in any state, mid-handshake included, SHALL abort immediately: pending muldiv or lsu transactions are dropped and responders are re-initialised by the same reset.
REQ-027 After rst_n rises, ifu_req SHALL first assert in the second cycle (IDLE for one cycle, then FETCH).

Configuration
REQ-028 Without the macro, cycle_cnt and inst_cnt SHALL be absent and no counter logic SHALL be instantiated.
REQ-029 Counter rules with the macro defined:
- cycle_cnt increments by 1 every cycle in states FETCH..WB;
- inst_cnt increments by 1 on each WB cycle;
- both are reset to 0, hold in HALT/TRAP, and wrap from 2^64-1 to 0.
REQ-030 The macro SHALL be named YSYX_25040109_PERF_CNT_EN.

Verification
REQ-031 Reset, then ifu_rvalid=1 constantly with an ALU instruction and reg_write_en_idu=1 -> states cycle 1,2,3,5; rf_wen and pc_we pulse once every 4 cycles; after 3 instructions inst_cnt=3 and cycle_cnt=12.
REQ-032 Load with lsu_done arriving 3 cycles after MEM entry -> lsu_req high for exactly 4 cycles, then one WB cycle; a store with reg_write_en_idu=0 -> rf_wen=0 and pc_we=1.
REQ-033 Muldiv with muldiv_done asserted on the first EXEC cycle -> a single muldiv_start pulse and a 4-cycle instruction; with done 5 cycles later -> still exactly one start pulse and EXEC lasts 6 cycles.
REQ-034 inst_invalid=1 together with is_ebreak=1 in DECODE -> TRAP, trap_illegal=1 and halt=1 held for 100 cycles, no further ifu_req, counters frozen.
REQ-035 Spurious lsu_done and muldiv_done pulses during FETCH -> no state change; rst_n pulsed low while in MEM -> immediately IDLE, all outputs 0, FETCH entered one cycle after release.
REQ-036 With the macro defined, preload cycle_cnt near 2^64-1 by force -> wraps to 0 with no glitch on inst_cnt.

Source files
------------

// File: rtl/ysyx_25040109_core_ctrl.sv
// ysyx_25040109_core_ctrl
// Multi-cycle control FSM for a simple core. It sequences instruction fetch,
// decode, execute (including the multi-cycle mul/div unit), memory access
// and write-back. An illegal instruction ends in TRAP and an ebreak ends in
// HALT. Both states are left only through reset.
//
// Optional build feature: define YSYX_25040109_PERF_CNT_EN to add the 64-bit
// cycle_cnt and inst_cnt performance counters. Without the macro the ports
// and all counter logic are absent.
//
// Handshake semantics, which apply to every responder port:
//   ifu_req and lsu_req are level requests. Each one stays high for every
//   cycle the FSM waits in FETCH or MEM. The matching response (ifu_rvalid or
//   lsu_done) is sampled only in that state, and the FSM advances on the
//   same rising edge. muldiv_start is a single-cycle pulse on the first EXEC
//   cycle. muldiv_done is sampled on every EXEC cycle, including the first.
//   A response that arrives outside its owning state is ignored.
//   All strobes are decoded combinationally from the state register and the
//   current inputs. inst_we is therefore high in the same cycle as
//   ifu_rvalid.
module ysyx_25040109_core_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   // instruction fetch
   output logic        ifu_req,
   input  logic        ifu_rvalid,
   output logic        inst_we,
   // decode status, valid from DECODE through WB
   input  logic        inst_invalid,
   input  logic        reg_write_en_idu,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_muldiv,
   input  logic        is_ebreak,
   // multiply/divide unit
   output logic        muldiv_start,
   input  logic        muldiv_done,
   // load/store unit
   output logic        lsu_req,
   input  logic        lsu_done,
   // write-back strobes
   output logic        rf_wen,
   output logic        pc_we,
   // status
   output logic        halt,
   output logic        trap_illegal,
   output logic [2:0]  state_o
`ifdef YSYX_25040109_PERF_CNT_EN
   ,
   output logic [63:0] cycle_cnt,
   output logic [63:0] inst_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_TRAP   = 3'd7
   } state_e;

   state_e state_q, state_d;

   // EXEC is entered only from DECODE. This flag is therefore high exactly
   // on the first EXEC cycle, which is where muldiv_start must fire.
   logic exec_first_q, exec_first_d;

   logic need_mem;
   assign need_mem = is_load | is_store;

   // Next-state selection for the instruction sequence
   always_comb begin
      state_d      = state_q;
      exec_first_d = (state_q == S_DECODE);
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (ifu_rvalid) state_d = S_DECODE;
         S_DECODE: begin
            if (inst_invalid)   state_d = S_TRAP;
            else if (is_ebreak) state_d = S_HALT;
            else                state_d = S_EXEC;
         end
         S_EXEC: begin
            // A non-muldiv instruction leaves after one cycle. A muldiv
            // instruction waits for done, which may already be high on the
            // first cycle.
            if (!is_muldiv || muldiv_done)
               state_d = need_mem ? S_MEM : S_WB;
         end
         S_MEM:    if (lsu_done) state_d = S_WB;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_IDLE;
      endcase
   end

   // State register; reset aborts any pending handshake at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         exec_first_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         exec_first_q <= exec_first_d;
      end
   end

   // Strobe decode from the current state and the live inputs
   always_comb begin
      ifu_req      = 1'b0;
      inst_we      = 1'b0;
      muldiv_start = 1'b0;
      lsu_req      = 1'b0;
      rf_wen       = 1'b0;
      pc_we        = 1'b0;
      halt         = 1'b0;
      trap_illegal = 1'b0;
      case (state_q)
         S_FETCH: begin
            ifu_req = 1'b1;
            inst_we = ifu_rvalid;
         end
         S_EXEC:  muldiv_start = is_muldiv & exec_first_q;
         S_MEM:   lsu_req = 1'b1;
         S_WB: begin
            rf_wen = reg_write_en_idu;
            pc_we  = 1'b1;
         end
         S_HALT:  halt = 1'b1;
         S_TRAP: begin
            halt         = 1'b1;
            trap_illegal = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_o = state_q;

`ifdef YSYX_25040109_PERF_CNT_EN
   logic [63:0] cycle_cnt_q, cycle_cnt_d;
   logic [63:0] inst_cnt_q,  inst_cnt_d;
   logic        active;

   // Only the working states advance the counters. IDLE, HALT and TRAP
   // freeze them.
   assign active = (state_q == S_FETCH)  || (state_q == S_DECODE) ||
                   (state_q == S_EXEC)   || (state_q == S_MEM)    ||
                   (state_q == S_WB);

   // Counter next values; both wrap naturally at 2^64
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      inst_cnt_d  = inst_cnt_q;
      if (active)          cycle_cnt_d = cycle_cnt_q + 64'd1;
      if (state_q == S_WB) inst_cnt_d  = inst_cnt_q + 64'd1;
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q <= 64'd0;
         inst_cnt_q  <= 64'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         inst_cnt_q  <= inst_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign inst_cnt  = inst_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25040109_core_ctrl.sv
// Testbench for ysyx_25040109_core_ctrl.
// The reference model describes each instruction as a list of phases with
// known lengths (fetch wait, decode, exec, mem wait, write-back, terminal).
// It expands these into a per-cycle queue of expected outputs and a matching
// queue of stimulus. Responder delays and junk inputs are randomized.
module tb_ysyx_25040109_core_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ifu_rvalid = 1'b0, muldiv_done = 1'b0, lsu_done = 1'b0;
   logic        inst_invalid = 1'b0, reg_write_en_idu = 1'b0, is_load = 1'b0;
   logic        is_store = 1'b0, is_muldiv = 1'b0, is_ebreak = 1'b0;
   logic        ifu_req, inst_we, muldiv_start, lsu_req, rf_wen, pc_we;
   logic        halt, trap_illegal;
   logic [2:0]  state_o;
`ifdef YSYX_25040109_PERF_CNT_EN
   logic [63:0] cycle_cnt, inst_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Expected per-cycle output: {state[2:0], ifu_req, inst_we, muldiv_start,
   // lsu_req, rf_wen, pc_we, halt, trap_illegal}
   logic [10:0] exp_q[$];
   // Stimulus per cycle: {ifu_rvalid, muldiv_done, lsu_done, inst_invalid,
   // reg_write_en_idu, is_load, is_store, is_muldiv, is_ebreak}
   logic [8:0]  drv_q[$];
   logic [63:0] exp_cyc, exp_inst;

   localparam logic [2:0] P_IDLE = 3'd0, P_FETCH = 3'd1, P_DECODE = 3'd2,
                          P_EXEC = 3'd3, P_MEM = 3'd4, P_WB = 3'd5,
                          P_HALT = 3'd6, P_TRAP = 3'd7;

   ysyx_25040109_core_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ifu_req          (ifu_req),
      .ifu_rvalid       (ifu_rvalid),
      .inst_we          (inst_we),
      .inst_invalid     (inst_invalid),
      .reg_write_en_idu (reg_write_en_idu),
      .is_load          (is_load),
      .is_store         (is_store),
      .is_muldiv        (is_muldiv),
      .is_ebreak        (is_ebreak),
      .muldiv_start     (muldiv_start),
      .muldiv_done      (muldiv_done),
      .lsu_req          (lsu_req),
      .lsu_done         (lsu_done),
      .rf_wen           (rf_wen),
      .pc_we            (pc_we),
      .halt             (halt),
      .trap_illegal     (trap_illegal),
      .state_o          (state_o)
`ifdef YSYX_25040109_PERF_CNT_EN
      ,
      .cycle_cnt        (cycle_cnt),
      .inst_cnt         (inst_cnt)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- model helpers ----------------
   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] r6();
      return 6'($urandom_range(0, 63));
   endfunction

   task automatic push(input logic [2:0] st, input logic [7:0] strb,
                       input logic [8:0] in);
      exp_q.push_back({st, strb});
      drv_q.push_back(in);
   endtask

   // Expand one instruction into its expected cycles.
   // f = fetch wait cycles, m = cycles before muldiv_done,
   // l = cycles before lsu_done, tail = cycles spent in a terminal state.
   task automatic push_instr(input bit inv, input bit eb, input bit ld,
                             input bit sto, input bit md, input bit wen,
                             input int f, input int m, input int l,
                             input int tail);
      logic [5:0] d;
      d = {inv, wen, ld, sto, md, eb};
      for (int i = 0; i < f; i++)
         push(P_FETCH, 8'b1000_0000, {1'b0, rb(), rb(), r6()});
      push(P_FETCH, 8'b1100_0000, {1'b1, rb(), rb(), r6()});
      push(P_DECODE, 8'b0, {rb(), rb(), rb(), d});
      if (inv) begin
         for (int i = 0; i < tail; i++)
            push(P_TRAP, 8'b0000_0011, {rb(), rb(), rb(), r6()});
         return;
      end
      if (eb) begin
         for (int i = 0; i < tail; i++)
            push(P_HALT, 8'b0000_0010, {rb(), rb(), rb(), r6()});
         return;
      end
      if (md) begin
         for (int i = 0; i <= m; i++)
            push(P_EXEC, {2'b00, (i == 0), 5'b0}, {rb(), (i == m), rb(), d});
      end else begin
         push(P_EXEC, 8'b0, {rb(), rb(), rb(), d});
      end
      if (ld || sto) begin
         for (int i = 0; i <= l; i++)
            push(P_MEM, 8'b0001_0000, {rb(), rb(), (i == l), d});
      end
      push(P_WB, {4'b0000, wen, 1'b1, 2'b00}, {rb(), rb(), rb(), d});
   endtask

   // ---------------- driver tasks ----------------
   task automatic sample(output logic [138:0] o);
`ifdef YSYX_25040109_PERF_CNT_EN
      o = {cycle_cnt, inst_cnt, state_o, ifu_req, inst_we, muldiv_start,
           lsu_req, rf_wen, pc_we, halt, trap_illegal};
`else
      o = {128'b0, state_o, ifu_req, inst_we, muldiv_start,
           lsu_req, rf_wen, pc_we, halt, trap_illegal};
`endif
   endtask

   task automatic drive_random();
      {ifu_rvalid, muldiv_done, lsu_done, inst_invalid, reg_write_en_idu,
       is_load, is_store, is_muldiv, is_ebreak} = 9'($urandom_range(0, 511));
   endtask

   // Consume one queued cycle. Drive on the falling edge and sample 2 ns
   // later, well before the next rising edge.
   task automatic step(output logic [138:0] o, output logic [138:0] e);
      logic [10:0] x;
      logic [8:0]  v;
      x = exp_q.pop_front();
      v = drv_q.pop_front();
      @(negedge clk);
      {ifu_rvalid, muldiv_done, lsu_done, inst_invalid, reg_write_en_idu,
       is_load, is_store, is_muldiv, is_ebreak} = v;
      #2;
      sample(o);
`ifdef YSYX_25040109_PERF_CNT_EN
      e = {exp_cyc, exp_inst, x};
`else
      e = {128'b0, x};
`endif
      if (x[10:8] >= P_FETCH && x[10:8] <= P_WB) exp_cyc = exp_cyc + 64'd1;
      if (x[10:8] == P_WB) exp_inst = exp_inst + 64'd1;
   endtask

   // Assert reset mid-cycle, hold it for three cycles with random inputs,
   // then release it and observe the single IDLE cycle.
   task automatic apply_reset(input string nm);
      logic [138:0] o;
      exp_q.delete();
      drv_q.delete();
      exp_cyc  = 64'd0;
      exp_inst = 64'd0;
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_random();
         #2;
         sample(o);
         n_checks++;
         if (o !== 139'b0) begin
            n_fail++;
            $display("FAIL %s_in_reset cyc=%0d got=%h exp=0", nm, i, o);
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      drive_random();
      #2;
      sample(o);
      n_checks++;
      if (o !== 139'b0) begin
         n_fail++;
         $display("FAIL %s_idle_after_release got=%h exp=0", nm, o);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [138:0] o, e;
      apply_reset("reset");
      // The cycle after IDLE must be the first FETCH.
      push(P_FETCH, 8'b1000_0000, {1'b0, 8'b0});
      step(o, e);
      n_checks++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset_first_fetch got=%h exp=%h", o, e);
      end
   endtask

   task automatic test_alu_stream();
      logic [138:0] o, e;
      int cyc;
      apply_reset("alu");
      for (int i = 0; i < 3; i++) push_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      push(P_FETCH, 8'b1000_0000, {1'b0, 8'b0});
      cyc = 0;
      while (exp_q.size() > 0) begin
         step(o, e);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL alu_stream cyc=%0d got=%h exp=%h", cyc, o, e);
         end
         cyc++;
      end
   endtask

   task automatic test_load_store();
      logic [138:0] o, e;
      int cyc, lsu_cycles;
      apply_reset("ldst");
      push_instr(0, 0, 1, 0, 0, 1, 2, 0, 3, 0);  // load, done 3 cycles in
      push_instr(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);  // store, no reg write
      push_instr(0, 0, 1, 1, 0, 1, 0, 0, 1, 0);  // both flags: one MEM visit
      cyc = 0;
      lsu_cycles = 0;
      while (exp_q.size() > 0) begin
         step(o, e);
         if (o[7] === 1'b1 && cyc < 9) lsu_cycles++;
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL load_store cyc=%0d got=%h exp=%h", cyc, o, e);
         end
         cyc++;
      end
   endtask

   task automatic test_muldiv();
      logic [138:0] o, e;
      int cyc, starts;
      apply_reset("muldiv");
      push_instr(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);  // done on first EXEC cycle
      push_instr(0, 0, 0, 0, 1, 1, 0, 5, 0, 0);  // done 5 cycles later
      cyc = 0;
      starts = 0;
      while (exp_q.size() > 0) begin
         step(o, e);
         if (o[5] === 1'b1) starts++;
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL muldiv cyc=%0d got=%h exp=%h", cyc, o, e);
         end
         cyc++;
      end
      n_checks++;
      if (starts != 2) begin
         n_fail++;
         $display("FAIL muldiv_start_count got=%0d exp=2", starts);
      end
   endtask

   task automatic test_random();
      logic [138:0] o, e;
      int cyc, k;
      bit ld, sto, md;
      apply_reset("random");
      for (int i = 0; i < 40; i++) begin
         k   = $urandom_range(0, 5);
         ld  = (k == 1) || (k == 4);
         sto = (k == 2) || (k == 4) || (k == 5);
         md  = (k == 3) || (k == 5);
         push_instr(0, 0, ld, sto, md, rb(), $urandom_range(0, 3),
                    $urandom_range(0, 6), $urandom_range(0, 4), 0);
      end
      push_instr(0, 1, 0, 0, 0, 0, 1, 0, 0, 20);  // end with ebreak -> HALT
      cyc = 0;
      while (exp_q.size() > 0) begin
         step(o, e);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
         end
         cyc++;
      end
   endtask

   task automatic test_trap();
      logic [138:0] o, e;
      int cyc;
      apply_reset("trap");
      push_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      push_instr(1, 1, 0, 0, 0, 1, 1, 0, 0, 100);  // invalid wins over ebreak
      cyc = 0;
      while (exp_q.size() > 0) begin
         step(o, e);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL trap cyc=%0d got=%h exp=%h", cyc, o, e);
         end
         cyc++;
      end
   endtask

   task automatic test_reset_mid_mem();
      logic [138:0] o, e;
      int cyc;
      apply_reset("midmem_pre");
      push_instr(0, 0, 1, 0, 0, 1, 0, 0, 10, 0);
      for (int i = 0; i < 5; i++) begin  // FETCH, DECODE, EXEC, MEM, MEM
         step(o, e);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL midmem_lead cyc=%0d got=%h exp=%h", i, o, e);
         end
      end
      apply_reset("midmem");
      push_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         step(o, e);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL midmem_after cyc=%0d got=%h exp=%h", cyc, o, e);
         end
         cyc++;
      end
   endtask

`ifdef YSYX_25040109_PERF_CNT_EN
   task automatic test_perf_wrap();
      logic [138:0] o, e;
      int cyc;
      apply_reset("wrap");
      force dut.cycle_cnt_q = 64'hFFFF_FFFF_FFFF_FFFD;
      #1;
      release dut.cycle_cnt_q;
      exp_cyc = 64'hFFFF_FFFF_FFFF_FFFD;
      push_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      push_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         step(o, e);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL perf_wrap cyc=%0d got=%h exp=%h", cyc, o, e);
         end
         cyc++;
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_alu_stream();
      test_load_store();
      test_muldiv();
      test_random();
      test_trap();
      test_reset_mid_mem();
`ifdef YSYX_25040109_PERF_CNT_EN
      test_perf_wrap();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   // Absolute time bound in case a task stalls
   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
